// File: rtl/ql_dsp_mac_sequencer_if.sv
// ql_dsp_mac_sequencer_if: job, operand stream, result and DSP-side signals of the MAC sequencer
interface ql_dsp_mac_sequencer_if #(
    parameter int NBITS_A   = 20,
    parameter int NBITS_B   = 18,
    parameter int NBITS_Z   = 38,
    parameter int NBITS_LEN = 8
);
    logic                        start_i;
    logic [NBITS_LEN-1:0]        len_i;
    logic                        busy_o;
    logic                        done_o;
    logic                        op_valid_i;
    logic                        op_ready_o;
    logic signed [NBITS_A-1:0]   op_a_i;
    logic signed [NBITS_B-1:0]   op_b_i;
    logic                        res_valid_o;
    logic                        res_ready_i;
    logic signed [NBITS_Z-1:0]   res_data_o;
    logic signed [NBITS_A-1:0]   dsp_a_o;
    logic signed [NBITS_B-1:0]   dsp_b_o;
    logic                        dsp_load_acc_o;
    logic [2:0]                  dsp_feedback_o;
    logic signed [NBITS_Z-1:0]   dsp_z_i;

    modport slave (
        input  start_i, len_i, op_valid_i, op_a_i, op_b_i, res_ready_i, dsp_z_i,
        output busy_o, done_o, op_ready_o, res_valid_o, res_data_o,
               dsp_a_o, dsp_b_o, dsp_load_acc_o, dsp_feedback_o
    );

    modport master (
        output start_i, len_i, op_valid_i, op_a_i, op_b_i, res_ready_i, dsp_z_i,
        input  busy_o, done_o, op_ready_o, res_valid_o, res_data_o,
               dsp_a_o, dsp_b_o, dsp_load_acc_o, dsp_feedback_o
    );
endinterface

// File: rtl/ql_dsp_mac_sequencer.sv
// ql_dsp_mac_sequencer: streams an N-element signed dot product through one full-mode ql_dsp_tsmc
module ql_dsp_mac_sequencer #(
    parameter int NBITS_A   = 20,
    parameter int NBITS_B   = 18,
    parameter int NBITS_Z   = 38,
    parameter int NBITS_LEN = 8,
    parameter int DSP_LAT   = 2
) (
    input logic                   clock_i,
    input logic                   reset_n_i,
    ql_dsp_mac_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, HOLD} state_t;

    state_t               state;
    logic [NBITS_LEN-1:0] remaining;
    logic [3:0]           drain;
    logic                 first;
    logic                 accept;

    assign accept     = bus.op_valid_i & bus.op_ready_o;
    assign bus.done_o = bus.res_valid_o & bus.res_ready_i;

    // Drain covers the registered drive stage plus DSP latency, so Z is captured once it holds the last product
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state              <= IDLE;
            remaining          <= '0;
            drain              <= '0;
            first              <= 1'b0;
            bus.busy_o         <= 1'b0;
            bus.op_ready_o     <= 1'b0;
            bus.res_valid_o    <= 1'b0;
            bus.res_data_o     <= '0;
            bus.dsp_a_o        <= '0;
            bus.dsp_b_o        <= '0;
            bus.dsp_load_acc_o <= 1'b0;
            bus.dsp_feedback_o <= 3'b000;
        end else begin
            bus.dsp_load_acc_o <= accept;
            bus.dsp_a_o        <= accept ? bus.op_a_i : {NBITS_A{1'b0}};
            bus.dsp_b_o        <= accept ? bus.op_b_i : {NBITS_B{1'b0}};
            bus.dsp_feedback_o <= (accept && first) ? 3'b001 : 3'b000;
            case (state)
                IDLE: if (bus.start_i) begin
                    bus.busy_o <= 1'b1;
                    if (bus.len_i != '0) begin
                        remaining      <= bus.len_i;
                        first          <= 1'b1;
                        bus.op_ready_o <= 1'b1;
                        state          <= RUN;
                    end else begin
                        bus.res_data_o  <= {NBITS_Z{1'b0}};
                        bus.res_valid_o <= 1'b1;
                        state           <= HOLD;
                    end
                end
                RUN: if (accept) begin
                    first     <= 1'b0;
                    remaining <= remaining - 1'b1;
                    if (remaining == NBITS_LEN'(1)) begin
                        bus.op_ready_o <= 1'b0;
                        drain          <= 4'(DSP_LAT + 1);
                        state          <= DRAIN;
                    end
                end
                DRAIN: begin
                    drain <= drain - 4'd1;
                    if (drain == 4'd1) begin
                        bus.res_data_o  <= bus.dsp_z_i;
                        bus.res_valid_o <= 1'b1;
                        state           <= HOLD;
                    end
                end
                HOLD: if (bus.res_ready_i) begin
                    bus.res_valid_o <= 1'b0;
                    bus.busy_o      <= 1'b0;
                    state           <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
